ins_miss_queue: RTL

//  Downstream stage of the instruction cache. Captures 26-bit line addresses issued on

---
 rtl/ins_miss_queue.sv | 110 +++++++++++
 1 files changed

// File: rtl/ins_miss_queue.sv
// ins_miss_queue: I-cache miss FIFO replaying line addresses to next-level memory over req/ack.
// Define MISS_COALESCE_EN to merge misses matching a queued or in-flight line.
module ins_miss_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 26,
   parameter int CW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          miss_valid,
   input  logic [AW-1:0] miss_addr,
   output logic          full,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   output logic          fill_valid,
   output logic [AW-1:0] fill_addr,
   output logic [CW-1:0] req_cnt,
   output logic [CW-1:0] drop_cnt,
   output logic [CW-1:0] merge_cnt
);
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
   state_e          state_q;
   logic [AW-1:0]   mem_q [DEPTH];
   logic [PW-1:0]   wr_q, rd_q;
   logic [CNTW-1:0] count_q, count_d;
   logic            mem_req_q, fill_valid_q;
   logic [AW-1:0]   mem_addr_q, fill_addr_q;
   logic [CW-1:0]   req_cnt_q, drop_cnt_q;
   logic            dup, push, pop, drop;
`ifdef MISS_COALESCE_EN
   logic            hit, merge;
   logic [CW-1:0]   merge_cnt_q;
   // The in-flight head stays a valid entry until its ack, so it is covered by the scan too.
   always_comb begin
      hit = (state_q == ISSUE) && (miss_addr == mem_addr_q);
      for (int i = 0; i < DEPTH; i++)
         if (({1'b0, PW'(PW'(i) - rd_q)} < count_q) && (mem_q[i] == miss_addr)) hit = 1'b1;
   end
   assign dup   = hit;
   assign merge = miss_valid && !flush && dup;
   always_ff @(posedge clk) begin
      if (!rst_n || flush) merge_cnt_q <= '0;
      else merge_cnt_q <= merge_cnt_q + CW'(merge);
   end
   assign merge_cnt = merge_cnt_q;
`else
   assign dup       = 1'b0;
   assign merge_cnt = '0;
`endif
   assign full    = count_q == CNTW'(DEPTH);
   assign push    = miss_valid && !flush && !dup && !full;
   assign drop    = miss_valid && !flush && !dup && full;
   assign pop     = (state_q == ISSUE) && mem_ack && !flush;
   assign count_d = count_q + CNTW'(push) - CNTW'(pop);
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= miss_addr;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_q         <= '0;
         rd_q         <= '0;
         count_q      <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         fill_valid_q <= 1'b0;
         fill_addr_q  <= '0;
         req_cnt_q    <= '0;
         drop_cnt_q   <= '0;
      end else begin
         fill_valid_q <= 1'b0;
         wr_q         <= flush ? '0 : wr_q + PW'(push);
         rd_q         <= flush ? '0 : rd_q + PW'(pop);
         count_q      <= flush ? '0 : count_d;
         req_cnt_q    <= flush ? '0 : req_cnt_q + CW'(pop);
         drop_cnt_q   <= flush ? '0 : drop_cnt_q + CW'(drop);
         case (state_q)
            IDLE:
               if (count_q != '0 && !flush) begin
                  state_q    <= ISSUE;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= mem_q[rd_q];
               end
            ISSUE:
               if (mem_ack) begin
                  state_q      <= IDLE;
                  mem_req_q    <= 1'b0;
                  fill_valid_q <= !flush;
                  fill_addr_q  <= mem_addr_q;
               end else if (flush) state_q <= DRAIN;
            DRAIN:
               if (mem_ack) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
               end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign fill_valid = fill_valid_q;
   assign fill_addr  = fill_addr_q;
   assign req_cnt    = req_cnt_q;
   assign drop_cnt   = drop_cnt_q;
endmodule
